// File: rtl/ad_axis_inf_tx_if.sv
// AXI-stream handshake bundle feeding the transmit bridge.
// master drives the stream; slave (the bridge) returns ready.
interface ad_axis_inf_tx_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  inf_valid;
  logic                  inf_last;
  logic [DATA_WIDTH-1:0] inf_data;
  logic                  inf_ready;

  modport master (
    output inf_valid,
    output inf_last,
    output inf_data,
    input  inf_ready
  );

  modport slave (
    input  inf_valid,
    input  inf_last,
    input  inf_data,
    output inf_ready
  );
endinterface

// File: rtl/ad_axis_inf_tx.sv
// AXI-stream slave to core bridge: small circular buffer drained one word per rd strobe.
// Optional registered occupancy output enabled by AD_AXIS_INF_TX_LEVEL_EN.
module ad_axis_inf_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  ad_axis_inf_tx_if.slave       inf,
  input  logic                  rd,
  output logic                  valid,
  output logic                  last,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  underflow
`ifdef AD_AXIS_INF_TX_LEVEL_EN
  ,
  output logic [ADDR_WIDTH:0]   level
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;

  // Pointer MSB is the wrap bit, distinguishing full from empty.
  logic [ADDR_WIDTH:0] wptr;
  logic [ADDR_WIDTH:0] rptr;
  logic [DATA_WIDTH:0] mem [DEPTH];

  logic empty;
  logic full;
  logic wr_en;
  logic rd_en;

  assign empty = (wptr == rptr);
  assign full  = (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]) &&
                 (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]);

  assign inf.inf_ready = ~full & ~rst;
  assign wr_en = inf.inf_valid & inf.inf_ready;
  assign rd_en = rd & ~empty;

  // NOTE: storage has no reset; pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr[ADDR_WIDTH-1:0]] <= {inf.inf_last, inf.inf_data};
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      valid     <= 1'b0;
      last      <= 1'b0;
      data      <= '0;
      underflow <= 1'b0;
    end else begin
      if (wr_en) begin
        wptr <= wptr + PTR_ONE;
      end
      if (rd_en) begin
        rptr <= rptr + PTR_ONE;
        {last, data} <= mem[rptr[ADDR_WIDTH-1:0]];
      end else begin
        {last, data} <= '0;
      end
      valid     <= rd_en;
      underflow <= rd & empty;
    end
  end

`ifdef AD_AXIS_INF_TX_LEVEL_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      level <= '0;
    end else begin
      level <= wptr - rptr;
    end
  end
`endif

endmodule

// File: doc/ad_axis_inf_tx.md
Name: ad_axis_inf_tx

Overview:
AXI-stream slave to core-interface bridge, the transmit-side counterpart of the core receive bridge. Accepts a stream (inf_valid/inf_ready/inf_last/inf_data) into a small circular buffer. A core clocked on clk pulls one word per rd strobe with no backpressure. Sits between DMA/AXIS fabric and a DAC/transmit core.

Parameters:
DATA_WIDTH, 16, width of inf_data and data
ADDR_WIDTH, 3, buffer address width; DEPTH = 2**ADDR_WIDTH entries (default 8)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
inf_valid  input  1  AXIS slave valid
inf_last  input  1  AXIS slave last
inf_data  input  DATA_WIDTH  AXIS slave data
inf_ready  output  1  AXIS slave ready
rd  input  1  core read strobe, one word per cycle high
valid  output  1  core data valid, registered
last  output  1  core last flag, registered
data  output  DATA_WIDTH  core data, registered
underflow  output  1  one-cycle pulse: rd while buffer empty

Behaviour:
- Pointers: wptr and rptr, each ADDR_WIDTH+1 bits; the MSB is the wrap bit. Both reset to 0.
- empty = (wptr == rptr).
- full = (low bits equal) and (wrap bits differ).
- inf_ready = ~full & ~rst. It is combinational from registered pointers. It is 0 while rst is high.
- Write: when inf_valid & inf_ready, store {inf_last, inf_data} at wptr[ADDR_WIDTH-1:0] and increment wptr. Increment wraps modulo 2**(ADDR_WIDTH+1).
- Buffer storage is not reset. Contents are don't-care after reset.
- Read, evaluated each cycle when not in reset:
  - rd=1 and not empty: next cycle valid=1, last and data = entry at rptr; rptr increments.
  - rd=1 and empty: next cycle valid=0, last=0, data=0, underflow=1; rptr unchanged.
  - rd=0: next cycle valid=0, last=0, data=0, underflow=0.
- Latency: rd to valid is 1 cycle. inf_valid accept to earliest readable is 1 cycle. There is no same-cycle bypass: a write and rd in the same cycle on an empty buffer gives underflow.
- Simultaneous write and read while not full/empty: both occur and occupancy is unchanged.
- When full, inf_ready=0 even if rd=1 that cycle. inf_ready rises the cycle after the read.
- Occupancy never exceeds DEPTH. Wrap at entry DEPTH-1 to 0 is seamless.
- Reset (including mid-transfer): next edge sets wptr=rptr=0, valid=0, last=0, data=0, underflow=0. Buffered words are discarded. inf_ready=0 during rst and 1 the first cycle after.
- The last flag is carried through unmodified. The block does no packet framing.

Optional Feature:
Macro: AD_AXIS_INF_TX_LEVEL_EN
- Defined: adds output port level, width ADDR_WIDTH+1.
  - level is a registered occupancy, equal to (wptr - rptr) of the previous cycle, mod 2**(ADDR_WIDTH+1).
  - Range is 0..DEPTH. It resets to 0.
- Undefined: the level port and its logic are absent. All other behaviour is identical.

Test Plan:
1. Reset then idle: hold rst 3 cycles, release -> valid=0, last=0, data=0, underflow=0; inf_ready=0 during rst, 1 after; level=0 if enabled.
2. Basic transfer: push 0x0001..0x0004 with inf_last on 0x0004, then rd high 4 cycles -> valid high 4 consecutive cycles starting 1 cycle after rd, data 0x0001..0x0004, last=1 only with 0x0004.
3. Fill/backpressure: push continuously with rd=0 -> exactly 8 accepted, inf_ready=0 from the cycle after the 8th accept. Single rd -> data=first word, inf_ready=1 one cycle later, 9th word accepted.
4. Underflow: empty buffer, rd=1 for 2 cycles -> underflow=1 for 2 cycles, valid=0, data=0. Push 0xABCD with rd=1 the same cycle -> underflow that cycle, 0xABCD delivered on the next rd.
5. Wrap: stream 20 words 0x0000..0x0013 with rd high every other cycle and inf_valid always high -> output sequence in order with no loss or duplication; no underflow after first fill.
6. Mid-operation reset: 5 words buffered, pulse rst 1 cycle -> valid=0 next cycle; subsequent rd gives underflow; new push 0x5555 is read back as first word.
